// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state codes
// and the packed control-output bundle with its per-case values.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_ST_RUN      = 2'b00,
        HZ_ST_MEM_WAIT = 2'b01,
        HZ_ST_ERR      = 2'b11
    } hz_state_e;

    // Field order: pc_write, if_id_write, if_id_flush,
    // id_ex_flush, ex_mem_hold.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_hold;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_RST  = 5'b00110;
    localparam hz_ctl_t CTL_HOLD = 5'b00001;
    localparam hz_ctl_t CTL_RDR  = 5'b11110;
    localparam hz_ctl_t CTL_LU   = 5'b00010;
    localparam hz_ctl_t CTL_NORM = 5'b11000;

    function automatic logic lu_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic       use1,
        input logic [4:0] rs1,
        input logic       use2,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX operand info, dmem status in;
// stage enables, flushes, hold, debug state, error (and perf) out.
// Perf counter signals exist only with HAZARD_PERF_CNT_EN.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_hold;
    logic [1:0] hz_state;
    logic       err_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_stall;
    logic [CNT_W-1:0] perf_mem_stall;
    logic [CNT_W-1:0] perf_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_redirect,
        output dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush,
        input  id_ex_flush, ex_mem_hold,
        input  hz_state, err_timeout,
        input  perf_lu_stall, perf_mem_stall, perf_flush
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_redirect,
        input  dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush,
        output id_ex_flush, ex_mem_hold,
        output hz_state, err_timeout,
        output perf_lu_stall, perf_mem_stall, perf_flush
    );
`else
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_redirect,
        output dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush,
        input  id_ex_flush, ex_mem_hold,
        input  hz_state, err_timeout
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_redirect,
        input  dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush,
        output id_ex_flush, ex_mem_hold,
        output hz_state, err_timeout
    );
`endif
endinterface

// File: rtl/hazard_perf_cnt.sv
// Three free-running wrap-around event counters with increment strobes.
// Ports: clk, rst (sync, active-high), inc_* strobes, *_cnt values.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_lu,
    input  logic             inc_mem,
    input  logic             inc_flush,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt    <= '0;
            mem_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (inc_lu)    lu_cnt    <= lu_cnt + 1'b1;
            if (inc_mem)   mem_cnt   <= mem_cnt + 1'b1;
            if (inc_flush) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, dmem wait
// with timeout. Ports: clk, rst (sync, active-high), hz (slave bundle).
// Macro HAZARD_PERF_CNT_EN adds perf counters (hazard_perf_cnt).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int WCW = $clog2(MAX_WAIT) + 1;
    localparam logic [WCW-1:0] CNT_LAST = WCW'(MAX_WAIT - 1);

    hz_state_e      state;
    logic [WCW-1:0] wait_cnt;
    logic           err_q;
    logic           mem_busy;
    logic           lu;
    hz_ctl_t        ctl;

    assign mem_busy = hz.dmem_req & ~hz.dmem_ready;
    assign lu = lu_hit(hz.ex_mem_read, hz.ex_rd,
                       hz.id_use_rs1, hz.id_rs1,
                       hz.id_use_rs2, hz.id_rs2);

    // A pending redirect or load-use waits out a dmem stall: EX is
    // frozen, so it is simply re-evaluated once the access completes.
    always_comb begin
        ctl = CTL_NORM;
        priority case (1'b1)
            rst:                 ctl = CTL_RST;
            state == HZ_ST_ERR:  ctl = CTL_HOLD;
            mem_busy:            ctl = CTL_HOLD;
            hz.ex_redirect:      ctl = CTL_RDR;
            lu:                  ctl = CTL_LU;
            default:             ctl = CTL_NORM;
        endcase
    end

    assign hz.pc_write    = ctl.pc_write;
    assign hz.if_id_write = ctl.if_id_write;
    assign hz.if_id_flush = ctl.if_id_flush;
    assign hz.id_ex_flush = ctl.id_ex_flush;
    assign hz.ex_mem_hold = ctl.ex_mem_hold;
    assign hz.hz_state    = state;
    assign hz.err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HZ_ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                HZ_ST_RUN: begin
                    if (mem_busy) begin
                        state    <= HZ_ST_MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                HZ_ST_MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= HZ_ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Counter saturates here; only rst leaves ERR.
                        state <= HZ_ST_ERR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HZ_ST_ERR: state <= HZ_ST_ERR;
                default:   state <= HZ_ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic live;
    logic inc_lu;
    logic inc_mem;
    logic inc_flush;

    // Strobes follow the winning priority case; ERR freezes all.
    assign live      = ~rst & (state != HZ_ST_ERR);
    assign inc_mem   = live & mem_busy;
    assign inc_flush = live & ~mem_busy & hz.ex_redirect;
    assign inc_lu    = live & ~mem_busy & ~hz.ex_redirect & lu;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .inc_lu    (inc_lu),
        .inc_mem   (inc_mem),
        .inc_flush (inc_flush),
        .lu_cnt    (hz.perf_lu_stall),
        .mem_cnt   (hz.perf_mem_stall),
        .flush_cnt (hz.perf_flush)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_WAIT=4).
// Perf counter checks are active with HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    localparam int CW = 8;

    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] st;
        logic       err;
    } exp_t;

    localparam logic [4:0] E_RST  = 5'b00110;
    localparam logic [4:0] E_HOLD = 5'b00001;
    localparam logic [4:0] E_RDR  = 5'b11110;
    localparam logic [4:0] E_LU   = 5'b00010;
    localparam logic [4:0] E_NORM = 5'b11000;
    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] MW  = 2'b01;
    localparam logic [1:0] ERR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    hazard_ctrl_if #(.CNT_W(CW)) hz();

    hazard_ctrl #(
        .MAX_WAIT (4),
        .CNT_W    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary, want end of run");
        $fatal(1, "watchdog expired");
    end

    task automatic step(
        input string      tag,
        input logic       r,
        input logic [4:0] rs1,
        input logic       u1,
        input logic [4:0] rs2,
        input logic       u2,
        input logic [4:0] rd,
        input logic       mr,
        input logic       rdr,
        input logic       req,
        input logic       rdy,
        input logic [4:0] ctl,
        input logic [1:0] st,
        input logic       err
    );
        exp_t  e;
        exp_t  o;
        string t;
        @(posedge clk);
        #1;
        rst            = r;
        hz.id_rs1      = rs1;
        hz.id_use_rs1  = u1;
        hz.id_rs2      = rs2;
        hz.id_use_rs2  = u2;
        hz.ex_rd       = rd;
        hz.ex_mem_read = mr;
        hz.ex_redirect = rdr;
        hz.dmem_req    = req;
        hz.dmem_ready  = rdy;
        exp_q.push_back({ctl, st, err});
        tag_q.push_back(tag);
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: got empty queue, want entry", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                 hz.id_ex_flush, hz.ex_mem_hold,
                 hz.hz_state, hz.err_timeout};
            assert (o === e) passed++;
            else $error("FAIL %s: got ctl=%b st=%b err=%b, want ctl=%b st=%b err=%b",
                        t, o.ctl, o.st, o.err, e.ctl, e.st, e.err);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_perf(
        input string         tag,
        input logic [CW-1:0] lu_e,
        input logic [CW-1:0] mem_e,
        input logic [CW-1:0] fl_e
    );
        logic [3*CW-1:0] o;
        logic [3*CW-1:0] e;
        o = {hz.perf_lu_stall, hz.perf_mem_stall, hz.perf_flush};
        e = {lu_e, mem_e, fl_e};
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got lu/mem/flush=%h, want %h", tag, o, e);
    endtask
`endif

    initial begin
        hz.id_rs1      = '0;
        hz.id_use_rs1  = 1'b0;
        hz.id_rs2      = '0;
        hz.id_use_rs2  = 1'b0;
        hz.ex_rd       = '0;
        hz.ex_mem_read = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.dmem_req    = 1'b0;
        hz.dmem_ready  = 1'b0;

        //     tag        r  rs1 u1 rs2 u2 rd mr rdr rq rdy exp
        step("reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,  RUN, 0);
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, RUN, 0);
        step("lu_rs1",    0, 5, 1, 0, 0, 5, 1, 0, 0, 0, E_LU,   RUN, 0);
        step("lu_clear",  0, 5, 1, 0, 0, 5, 0, 0, 0, 0, E_NORM, RUN, 0);
        step("x0_rd",     0, 0, 1, 0, 0, 0, 1, 0, 0, 0, E_NORM, RUN, 0);
        step("rs2_unused",0, 0, 0, 7, 0, 7, 1, 0, 0, 0, E_NORM, RUN, 0);
        step("lu_rs2",    0, 0, 0, 7, 1, 7, 1, 0, 0, 0, E_LU,   RUN, 0);
        step("rdr_lu",    0, 5, 1, 0, 0, 5, 1, 1, 0, 0, E_RDR,  RUN, 0);
        step("post_rdr",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, RUN, 0);
        step("busy1",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_HOLD, RUN, 0);
        step("busy2",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_HOLD, MW,  0);
        step("busy3",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_HOLD, MW,  0);
        step("ready_rdr", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_RDR,  MW,  0);
        step("back_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, RUN, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_mid", 8'd2, 8'd3, 8'd2);
`endif
        step("to_busy1",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD, RUN, 0);
        step("to_busy2",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD, MW,  0);
        step("to_busy3",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD, MW,  0);
        step("to_busy4",  0, 5, 1, 0, 0, 5, 1, 0, 1, 0, E_HOLD, MW,  0);
        step("err_enter", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_HOLD, ERR, 1);
        step("err_stuck", 0, 5, 1, 0, 0, 5, 1, 1, 1, 1, E_HOLD, ERR, 1);
        step("err_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HOLD, ERR, 1);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_frozen", 8'd2, 8'd7, 8'd2);
`endif
        step("err_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,  ERR, 1);
        step("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, RUN, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_clr", 8'd0, 8'd0, 8'd0);
`endif
        step("one_busy",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD, RUN, 0);
        step("one_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_NORM, MW,  0);
        step("one_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, RUN, 0);
        step("lu_after",  0, 9, 1, 0, 0, 9, 1, 0, 0, 0, E_LU,   RUN, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_end", 8'd0, 8'd1, 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
